// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: default width, counter sizing
// and the IDLE/ACCUM state encoding.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Bit counter width for a given operand width (operand width is 2..16).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand-bit input stream, result output and status of the serial adder.
//
// Handshake: a beat (a_bit/b_bit) transfers on a rising clk edge where
// in_valid and in_ready are both 1; a result (out_sum/out_carry) transfers
// on a rising clk edge where out_valid and out_ready are both 1. A producer
// holds valid and data until the transfer edge; the consumer may change
// ready freely. The state field exposes the FSM state for observation.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic             a_bit;
  logic             b_bit;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             busy;
  state_t           state;

  modport master (
    output in_valid, a_bit, b_bit, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, busy, state
  );

  modport slave (
    input  in_valid, a_bit, b_bit, out_ready,
    output in_ready, out_valid, out_sum, out_carry, busy, state
  );

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Single-bit combinational full adder used by the serial adder.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: takes operand bits LSB first, one pair per beat, and
// presents the WIDTH-bit sum plus carry-out once a full word has been taken.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;

  logic             beat;
  logic             last_beat;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] shifted;

  serial_fa_cell u_fa (
    .a    (bus.a_bit),
    .b    (bus.b_bit),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Input acceptance is blocked only while a finished result is stalled.
  always_comb begin
    bus.in_ready = !(valid_q && !bus.out_ready);
    beat         = bus.in_valid && bus.in_ready;
    last_beat    = (count_q == LAST_CNT);
    shifted      = {fa_sum, shift_q[WIDTH-1:1]};
  end

  // State register plus datapath registers; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      c_q     <= 1'b0;
      shift_q <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      c_q     <= c_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  // Next state: only a beat moves the FSM; the final beat of a word returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (beat) begin
      state_d = last_beat ? IDLE : ACCUM;
    end
  end

  // Datapath next values: accumulate per beat, load the result on the final beat.
  always_comb begin
    count_d = count_q;
    c_d     = c_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = valid_q;
    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
    if (beat) begin
      shift_d = shifted;
      if (last_beat) begin
        // A completion in the same cycle as a consume keeps out_valid high.
        count_d = '0;
        c_d     = 1'b0;
        sum_d   = shifted;
        carry_d = fa_cout;
        valid_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
        c_d     = fa_cout;
      end
    end
  end

  // Outputs: busy mirrors a partially accumulated word (ACCUM state).
  always_comb begin
    bus.busy      = (state_q == ACCUM);
    bus.state     = state_q;
    bus.out_valid = valid_q;
    bus.out_sum   = sum_q;
    bus.out_carry = carry_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed words, stalls, reset mid-word and a
// randomized run, all checked against plain-arithmetic expected results.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0] exp_q[$];

  // 0: out_ready always 1, 1: random, 2: held at 0
  int ready_mode = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out_ready changes shortly after each rising edge, per ready_mode.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_carry", 32'(bus.out_carry), 32'd0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
  endtask

  // Offer one bit pair until it is accepted (bounded).
  task automatic beat(input logic a, input logic b);
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 60) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a_bit = a;
      bus.b_bit = b;
      #1;
      acc = bus.in_ready;
      @(posedge clk);
      t++;
    end
    if (!acc) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a_bit = 1'($urandom_range(0, 1));
      bus.b_bit = 1'($urandom_range(0, 1));
    end
  endtask

  // Send a full word; gap_pct is the chance of an idle cycle before each beat.
  task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input int gap_pct);
    logic [W:0] exp;
    exp = {1'b0, a} + {1'b0, b};
    exp_q.push_back(exp);
    for (int i = 0; i < W; i++) begin
      while ($urandom_range(0, 99) < gap_pct) idle_cycles(1);
      beat(a[i], b[i]);
    end
    // The result must be visible one cycle after the final beat.
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    chk("latency_sum", 32'(bus.out_sum), 32'(exp[W-1:0]));
    chk("latency_carry", 32'(bus.out_carry), 32'(exp[W]));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic       prev_stall = 1'b0;
  logic [W:0] prev_res;

  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      #3;
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_result", 32'({bus.out_carry, bus.out_sum}), 32'(prev_res));
      end
      chk("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'({bus.out_carry, bus.out_sum}), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'({bus.out_carry, bus.out_sum}), 32'(e));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = {bus.out_carry, bus.out_sum};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic word, back-to-back beats.
    send_word(8'h5A, 8'h3C, 0);
    // Carry out, then a word proving the carry register cleared.
    send_word(8'hFF, 8'h01, 0);
    send_word(8'h01, 8'h01, 0);
    drain();

    // Stalled result while the next word is offered.
    ready_mode = 2;
    idle_cycles(2);
    send_word(8'hA5, 8'h7E, 0);
    fork
      send_word(8'hC3, 8'h4D, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          #2;
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          chk("stall_no_accum", 32'(bus.busy), 32'd0);
        end
        ready_mode = 0;
      end
    join
    drain();

    // Reset in the middle of a word discards it.
    for (int i = 0; i < 4; i++) beat(1'(8'hF0 >> i), 1'(8'h0F >> i));
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("midword_busy", 32'(bus.busy), 32'd1);
    do_reset();
    send_word(8'h12, 8'h34, 0);
    drain();

    // Randomized operands, random input gaps and random consumer stalls.
    ready_mode = 1;
    for (int n = 0; n < 100; n++) begin
      send_word(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 50);
    end
    ready_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
